// File: rtl/accel_mem_requester.sv
// Accelerator-side initiator for the data memory arbiter: buffered word writes, one block read.
// Optional ACCEL_STARVE_CNT_EN adds a saturating count of ungranted issue cycles (starve_cnt).
module accel_mem_requester #(
   parameter int WFIFO_DEPTH  = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         rd_req,
   input  logic [15:0]  rd_addr,
   output logic         rd_busy,
   output logic         rd_valid,
   output logic [511:0] rd_data,
   input  logic         wr_req,
   input  logic [15:0]  wr_addr,
   input  logic [31:0]  wr_data,
   output logic         wr_full,
   output logic         wr_empty,
   output logic [15:0]  mem_addr,
   output logic [31:0]  mem_wrt_data,
   output logic         mem_wrt_en,
   input  logic         mem_grant,
   input  logic [511:0] mem_rd_data
`ifdef ACCEL_STARVE_CNT_EN
   ,
   output logic [15:0]  starve_cnt
`endif
);

   localparam int PW = $clog2(WFIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;

   state_t          state;
   logic [15:0]     fifo_addr [WFIFO_DEPTH];
   logic [31:0]     fifo_data [WFIFO_DEPTH];
   logic [PW-1:0]   wptr;
   logic [PW-1:0]   rptr;
   logic [PW-1:0]   rptr_nxt;
   logic [CW-1:0]   count;
   logic [15:0]     rd_addr_q;
   logic [LW-1:0]   lat_cnt;
   logic            push;
   logic            pop;

   assign wr_full  = (count == CW'(WFIFO_DEPTH));
   assign wr_empty = (count == '0);
   assign push     = wr_req && !wr_full;
   assign pop      = (state == WR_ISSUE) && mem_grant;
   assign rptr_nxt = rptr + 1'b1;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wptr] <= wr_addr;
         fifo_data[wptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr_nxt;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Outputs are registered: each transition preloads what the next state presents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         mem_addr     <= '0;
         mem_wrt_data <= '0;
         mem_wrt_en   <= 1'b0;
         rd_busy      <= 1'b0;
         rd_valid     <= 1'b0;
         rd_data      <= '0;
         rd_addr_q    <= '0;
         lat_cnt      <= '0;
      end else begin
         rd_valid <= 1'b0;
         if (rd_req && !rd_busy) begin
            rd_busy   <= 1'b1;
            rd_addr_q <= {rd_addr[15:4], 4'h0};
         end
         case (state)
            IDLE: begin
               if (count != '0) begin
                  state        <= WR_ISSUE;
                  mem_addr     <= fifo_addr[rptr];
                  mem_wrt_data <= fifo_data[rptr];
                  mem_wrt_en   <= 1'b1;
               end else if (rd_busy) begin
                  state    <= RD_ISSUE;
                  mem_addr <= rd_addr_q;
               end
            end
            WR_ISSUE: begin
               if (mem_grant) begin
                  if (count > CW'(1)) begin
                     mem_addr     <= fifo_addr[rptr_nxt];
                     mem_wrt_data <= fifo_data[rptr_nxt];
                  end else begin
                     mem_wrt_en <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            RD_ISSUE: begin
               if (mem_grant) begin
                  state   <= RD_WAIT;
                  lat_cnt <= LW'(READ_LATENCY - 1);
               end
            end
            RD_WAIT: begin
               if (lat_cnt == '0) begin
                  rd_data  <= mem_rd_data;
                  rd_valid <= 1'b1;
                  rd_busy  <= 1'b0;
                  state    <= IDLE;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ACCEL_STARVE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if ((state == WR_ISSUE || state == RD_ISSUE) && !mem_grant
                   && starve_cnt != 16'hFFFF) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_accel_mem_requester.sv
// Directed bench for accel_mem_requester: a READ_LATENCY=1 and a READ_LATENCY=3 instance
// share stimulus, each backed by its own word memory with a pipelined block read port.
module tb_accel_mem_requester;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         rd_req;
   logic [15:0]  rd_addr;
   logic         wr_req;
   logic [15:0]  wr_addr;
   logic [31:0]  wr_data;
   logic         mem_grant;

   logic         rd_busy1, rd_valid1, wr_full1, wr_empty1, wen1;
   logic [511:0] rd_data1, mem_rd_data1, blk1;
   logic [15:0]  addr1;
   logic [31:0]  wdata1;
   logic         rd_busy3, rd_valid3, wr_full3, wr_empty3, wen3;
   logic [511:0] rd_data3, mem_rd_data3, blk3;
   logic [15:0]  addr3;
   logic [31:0]  wdata3;
`ifdef ACCEL_STARVE_CNT_EN
   logic [15:0]  starve1, starve3;
`endif

   logic [31:0]  words1 [256];
   logic [31:0]  words3 [256];
   logic [511:0] pipe1 [1];
   logic [511:0] pipe3 [3];
   logic [47:0]  wlog_q [$];
   int           wcyc_q [$];
   int           cyc = 0;
   int           checks = 0;
   int           failures = 0;

   always #5 clk = ~clk;

   accel_mem_requester #(.WFIFO_DEPTH(4), .READ_LATENCY(1)) dut (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy1),
      .rd_valid(rd_valid1), .rd_data(rd_data1), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_full(wr_full1), .wr_empty(wr_empty1), .mem_addr(addr1),
      .mem_wrt_data(wdata1), .mem_wrt_en(wen1), .mem_grant(mem_grant), .mem_rd_data(mem_rd_data1)
`ifdef ACCEL_STARVE_CNT_EN
      , .starve_cnt(starve1)
`endif
   );

   accel_mem_requester #(.WFIFO_DEPTH(4), .READ_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy3),
      .rd_valid(rd_valid3), .rd_data(rd_data3), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_full(wr_full3), .wr_empty(wr_empty3), .mem_addr(addr3),
      .mem_wrt_data(wdata3), .mem_wrt_en(wen3), .mem_grant(mem_grant), .mem_rd_data(mem_rd_data3)
`ifdef ACCEL_STARVE_CNT_EN
      , .starve_cnt(starve3)
`endif
   );

   initial begin
      for (int i = 0; i < 256; i++) begin
         words1[i] = 32'hC0DE_0000 | i;
         words3[i] = 32'hC0DE_0000 | i;
      end
   end

   assign mem_rd_data1 = pipe1[0];
   assign mem_rd_data3 = pipe3[2];

   // Memory models: granted writes update the word array, reads return the 16-word block.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 16; i++) begin
         blk1[i*32 +: 32] = words1[{addr1[7:4], 4'(i)}];
         blk3[i*32 +: 32] = words3[{addr3[7:4], 4'(i)}];
      end
      if (wen1 && mem_grant) words1[addr1[7:0]] <= wdata1;
      if (wen3 && mem_grant) words3[addr3[7:0]] <= wdata3;
      pipe1[0] <= blk1;
      pipe3[0] <= blk3;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end

   always @(negedge clk) begin
      if (wen1 && mem_grant) begin
         wlog_q.push_back({addr1, wdata1});
         wcyc_q.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int v1, v3, lat1, lat3;

   initial begin
      rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0;
      wr_addr = '0; wr_data = '0; mem_grant = 1'b0;
      repeat (3) tick();
      chk("rst_rd_busy", rd_busy1, 0);
      chk("rst_rd_valid", rd_valid1, 0);
      chk("rst_rd_data", rd_data1[63:0], 0);
      chk("rst_wr_full", wr_full1, 0);
      chk("rst_wr_empty", wr_empty1, 1);
      chk("rst_mem_addr", addr1, 0);
      chk("rst_mem_wdata", wdata1, 0);
      chk("rst_mem_wen", wen1, 0);
      rst_n = 1'b1;
      tick();

      // Reset while three writes wait ungranted.
      for (int k = 0; k < 3; k++) begin
         wr_req = 1'b1; wr_addr = 16'h0030 + 16'(k); wr_data = 32'hB0 + 32'(k);
         tick();
      end
      wr_req = 1'b0;
      tick();
      chk("pre_rst_wen", wen1, 1);
      chk("pre_rst_addr", addr1, 16'h0030);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wen", wen1, 0);
      chk("mid_rst_empty", wr_empty1, 1);
      chk("mid_rst_busy", rd_busy1, 0);
      tick();
      rst_n = 1'b1; mem_grant = 1'b1;
      wlog_q.delete(); wcyc_q.delete();
      repeat (5) tick();
      chk("rst_no_write", wlog_q.size(), 0);

      // Single write stalled for five ungranted cycles.
      mem_grant = 1'b0;
      wr_req = 1'b1; wr_addr = 16'h0055; wr_data = 32'h1234_5678;
      tick();
      wr_req = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("stall_wen", wen1, 1);
         chk("stall_addr", addr1, 16'h0055);
         tick();
      end
      chk("stall_wdata", wdata1, 32'h1234_5678);
      chk("stall_not_empty", wr_empty1, 0);
      chk("stall_no_pop", wlog_q.size(), 0);
      mem_grant = 1'b1;
      tick();
      chk("stall_pop_empty", wr_empty1, 1);
      chk("stall_pop_wen", wen1, 0);
      chk("stall_pop_count", wlog_q.size(), 1);
      chk("stall_pop_entry", wlog_q[0], {16'h0055, 32'h1234_5678});
`ifdef ACCEL_STARVE_CNT_EN
      chk("stall_starve", starve1, 5);
`endif

      // Fill to full, drop a fifth push, then drain back-to-back.
      mem_grant = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wr_req = 1'b1; wr_addr = 16'h0010 + 16'(k); wr_data = 32'hA0 + 32'(k);
         tick();
      end
      wr_req = 1'b0;
      chk("fill_full", wr_full1, 1);
      wr_req = 1'b1; wr_addr = 16'h0014; wr_data = 32'hA4;
      tick();
      wr_req = 1'b0;
      chk("drop_full", wr_full1, 1);
      wlog_q.delete(); wcyc_q.delete();
      mem_grant = 1'b1;
      repeat (6) tick();
      chk("drain_count", wlog_q.size(), 4);
      for (int k = 0; k < 4; k++)
         chk("drain_entry", wlog_q[k], {16'h0010 + 16'(k), 32'hA0 + 32'(k)});
      for (int k = 1; k < 4; k++)
         chk("drain_spacing", wcyc_q[k] - wcyc_q[k-1], 1);
      chk("drain_empty", wr_empty1, 1);

      // Write then read: write retires first, read sees its data.
      wlog_q.delete(); wcyc_q.delete();
      wr_req = 1'b1; wr_addr = 16'h0020; wr_data = 32'h0000_DEAD;
      tick();
      wr_req = 1'b0; rd_req = 1'b1; rd_addr = 16'h0023;
      tick();
      rd_req = 1'b0;
      chk("raw_busy", rd_busy1, 1);
      chk("raw_wr_first_en", wen1, 1);
      chk("raw_wr_first_addr", addr1, 16'h0020);
      tick();
      chk("raw_wr_done_en", wen1, 0);
      chk("raw_wr_logged", wlog_q.size(), 1);
      tick();
      chk("raw_rd_addr", addr1, 16'h0020);
      chk("raw_rd_wen", wen1, 0);
      chk("raw_no_valid_a", rd_valid1, 0);
      tick();
      chk("raw_no_valid_b", rd_valid1, 0);
      tick();
      chk("raw_valid", rd_valid1, 1);
      chk("raw_data_w0", rd_data1[31:0], 32'h0000_DEAD);
      chk("raw_data_w1", rd_data1[63:32], 32'hC0DE_0021);
      chk("raw_busy_clr", rd_busy1, 0);
      tick();
      chk("raw_valid_pulse", rd_valid1, 0);
      chk("raw_data_hold", rd_data1[31:0], 32'h0000_DEAD);

      // Read latency on both instances, with a second request while busy.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      mem_grant = 1'b1;
      rd_req = 1'b1; rd_addr = 16'h0047;
      tick();
      rd_addr = 16'h0080;
      tick();
      rd_req = 1'b0;
      chk("lat_issue_addr1", addr1, 16'h0040);
      chk("lat_issue_addr3", addr3, 16'h0040);
      chk("lat_busy1", rd_busy1, 1);
      tick();
      v1 = 0; v3 = 0; lat1 = 0; lat3 = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (rd_valid1) begin v1++; lat1 = i; end
         if (rd_valid3) begin v3++; lat3 = i; end
      end
      chk("lat1_cycles", lat1, 1);
      chk("lat3_cycles", lat3, 3);
      chk("lat1_pulses", v1, 1);
      chk("lat3_pulses", v3, 1);
      chk("lat1_data_lo", rd_data1[31:0], 32'hC0DE_0040);
      chk("lat1_data_hi", rd_data1[511:480], 32'hC0DE_004F);
      chk("lat3_data_lo", rd_data3[31:0], 32'hC0DE_0040);
      chk("lat_busy_clr", {rd_busy1, rd_busy3}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
